// File: rtl/blockram_access_arbiter_pkg.sv
// Shared types and constants for the block-RAM access arbiter.
package blockram_access_arbiter_pkg;

  localparam int BYTE_LEN_IN_BITS       = 8;
  localparam int ARB_PERF_COUNTER_WIDTH = 32;

  typedef enum logic {
    ARB_CLEAR_IDLE = 1'b0,
    ARB_CLEAR_BUSY = 1'b1
  } clear_state_t;

endpackage

// File: rtl/blockram_access_arbiter_if.sv
// Client-side request/response bundle of the block-RAM access arbiter.
interface blockram_access_arbiter_if #(
  parameter int NUM_REQUESTER              = 4,
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int SET_PTR_WIDTH_IN_BITS      = 6,
  parameter int WRITE_MASK_LEN             = 8
);
  logic [NUM_REQUESTER-1:0]                            write_request_valid_in;
  logic [NUM_REQUESTER*WRITE_MASK_LEN-1:0]             write_request_mask_flatted_in;
  logic [NUM_REQUESTER*SET_PTR_WIDTH_IN_BITS-1:0]      write_request_addr_flatted_in;
  logic [NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] write_request_data_flatted_in;
  logic [NUM_REQUESTER-1:0]                            write_request_ready_out;
  logic [NUM_REQUESTER-1:0]                            read_request_valid_in;
  logic [NUM_REQUESTER*SET_PTR_WIDTH_IN_BITS-1:0]      read_request_addr_flatted_in;
  logic [NUM_REQUESTER-1:0]                            read_request_ready_out;
  logic [NUM_REQUESTER-1:0]                            read_response_valid_out;
  logic                                                read_response_hit_out;
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               read_response_data_out;
  logic                                                clear_request_in;
  logic                                                clear_busy_out;
  logic                                                clear_done_out;

  modport master (
    output write_request_valid_in, write_request_mask_flatted_in,
           write_request_addr_flatted_in, write_request_data_flatted_in,
           read_request_valid_in, read_request_addr_flatted_in, clear_request_in,
    input  write_request_ready_out, read_request_ready_out, read_response_valid_out,
           read_response_hit_out, read_response_data_out, clear_busy_out, clear_done_out
  );

  modport slave (
    input  write_request_valid_in, write_request_mask_flatted_in,
           write_request_addr_flatted_in, write_request_data_flatted_in,
           read_request_valid_in, read_request_addr_flatted_in, clear_request_in,
    output write_request_ready_out, read_request_ready_out, read_response_valid_out,
           read_response_hit_out, read_response_data_out, clear_busy_out, clear_done_out
  );
endinterface

// File: rtl/blockram_access_arbiter_ram.sv
// Dual-port block RAM with byte mask, per-set written flag and one-cycle read latency.
module dual_port_blockram
  import blockram_access_arbiter_pkg::*;
#(
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int NUM_SET                    = 64,
  parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / BYTE_LEN_IN_BITS,
  parameter     CONFIG_MODE                = "WriteFirst"
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_write_en,
  input  logic [WRITE_MASK_LEN-1:0]             i_write_mask,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]      i_write_addr,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] i_write_data,
  input  logic                                  i_read_en,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]      i_read_addr,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] o_read_data,
  output logic                                  o_read_valid
);
  localparam bit WRITE_FIRST = (CONFIG_MODE == "WriteFirst");

  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] r_mem [NUM_SET];
  logic [NUM_SET-1:0]                    r_written;
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] w_merged;

  always_comb begin
    w_merged = r_mem[i_write_addr];
    for (int b = 0; b < WRITE_MASK_LEN; b++) begin
      if (i_write_mask[b])
        w_merged[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS] = i_write_data[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < NUM_SET; s++) r_mem[s] <= '0;
      r_written    <= '0;
      o_read_data  <= '0;
      o_read_valid <= 1'b0;
    end else begin
      if (i_write_en) begin
        r_mem[i_write_addr]     <= w_merged;
        r_written[i_write_addr] <= 1'b1;
      end
      // Same-set collision returns the merged word only in write-first mode.
      if (i_read_en) begin
        if (WRITE_FIRST && i_write_en && (i_write_addr == i_read_addr)) begin
          o_read_data  <= w_merged;
          o_read_valid <= 1'b1;
        end else begin
          o_read_data  <= r_mem[i_read_addr];
          o_read_valid <= r_written[i_read_addr];
        end
      end
    end
  end
endmodule

// File: rtl/blockram_access_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
module round_robin_arbiter #(
  parameter int NUM_REQUESTER = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQUESTER-1:0] i_req,
  input  logic                     i_accept,
  output logic [NUM_REQUESTER-1:0] o_grant
);
  localparam int PTR_W = (NUM_REQUESTER > 1) ? $clog2(NUM_REQUESTER) : 1;

  logic [PTR_W-1:0] r_last_grant;
  logic [PTR_W-1:0] w_grant_idx;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_grant     = '0;
    w_grant_idx = r_last_grant;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int off = 1; off <= NUM_REQUESTER; off++) begin
      w_idx = PTR_W'((int'(r_last_grant) + off) % NUM_REQUESTER);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_grant_idx    = w_idx;
        w_found        = 1'b1;
      end
    end
  end

  // Reset to the last client so client 0 wins the first contest.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_last_grant <= PTR_W'(NUM_REQUESTER - 1);
    else if (i_accept) r_last_grant <= w_grant_idx;
  end
endmodule

// File: rtl/blockram_access_arbiter.sv
// Arbitrates N clients onto one dual-port block RAM, with a clear-sweep engine.
// Optional BLOCKRAM_ARBITER_PERF_COUNTER_EN adds a saturating conflict counter output.
module blockram_access_arbiter
  import blockram_access_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTER              = 4,
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int NUM_SET                    = 64,
  parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / BYTE_LEN_IN_BITS,
  parameter     CONFIG_MODE                = "WriteFirst"
) (
  input  logic clk_in,
  input  logic reset_in,
`ifdef BLOCKRAM_ARBITER_PERF_COUNTER_EN
  output logic [ARB_PERF_COUNTER_WIDTH-1:0] conflict_count_out,
`endif
  blockram_access_arbiter_if.slave bus
);
  localparam int N = NUM_REQUESTER;
  localparam int W = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int A = SET_PTR_WIDTH_IN_BITS;
  localparam int M = WRITE_MASK_LEN;
  localparam logic [A-1:0] LAST_SET = A'(NUM_SET - 1);

  clear_state_t  r_state, w_state_next;
  logic [A-1:0]  r_clear_cnt, w_clear_cnt_next;
  logic          r_clear_done, w_clear_done_next;
  logic          w_clear_busy;

  logic [N-1:0]  w_wr_req, w_wr_grant, w_rd_grant;
  logic [M-1:0]  w_wr_mask;
  logic [A-1:0]  w_wr_addr, w_rd_addr;
  logic [W-1:0]  w_wr_data;

  logic          r_wr_en, r_rd_en, r_resp_en;
  logic [M-1:0]  r_wr_mask;
  logic [A-1:0]  r_wr_addr, r_rd_addr;
  logic [W-1:0]  r_wr_data;
  logic [N-1:0]  r_rd_id, r_resp_id;
  logic [W-1:0]  w_ram_data;
  logic          w_ram_valid;

  assign w_clear_busy = (r_state == ARB_CLEAR_BUSY);
  assign w_wr_req     = bus.write_request_valid_in & {N{~w_clear_busy}};

  round_robin_arbiter #(.NUM_REQUESTER(N)) u_wr_arb (
    .i_clk(clk_in), .i_rst(reset_in), .i_req(w_wr_req),
    .i_accept(|w_wr_grant), .o_grant(w_wr_grant)
  );

  round_robin_arbiter #(.NUM_REQUESTER(N)) u_rd_arb (
    .i_clk(clk_in), .i_rst(reset_in), .i_req(bus.read_request_valid_in),
    .i_accept(|w_rd_grant), .o_grant(w_rd_grant)
  );

  always_comb begin
    w_wr_mask = '0;
    w_wr_addr = '0;
    w_wr_data = '0;
    w_rd_addr = '0;
    for (int i = 0; i < N; i++) begin
      if (w_wr_grant[i]) begin
        w_wr_mask |= bus.write_request_mask_flatted_in[i*M +: M];
        w_wr_addr |= bus.write_request_addr_flatted_in[i*A +: A];
        w_wr_data |= bus.write_request_data_flatted_in[i*W +: W];
      end
      if (w_rd_grant[i]) w_rd_addr |= bus.read_request_addr_flatted_in[i*A +: A];
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_clear_cnt_next  = r_clear_cnt;
    w_clear_done_next = 1'b0;
    case (r_state)
      ARB_CLEAR_IDLE: begin
        if (bus.clear_request_in) begin
          w_state_next     = ARB_CLEAR_BUSY;
          w_clear_cnt_next = '0;
        end
      end
      ARB_CLEAR_BUSY: begin
        w_clear_cnt_next = r_clear_cnt + A'(1);
        if (r_clear_cnt == LAST_SET) begin
          w_state_next      = ARB_CLEAR_IDLE;
          w_clear_cnt_next  = '0;
          w_clear_done_next = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state      <= ARB_CLEAR_IDLE;
      r_clear_cnt  <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_clear_cnt  <= w_clear_cnt_next;
      r_clear_done <= w_clear_done_next;
    end
  end

  // Issue stage feeds the RAM; the read id rides one stage further to meet the data.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_wr_en   <= 1'b0;
      r_wr_mask <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_rd_id   <= '0;
      r_resp_en <= 1'b0;
      r_resp_id <= '0;
    end else begin
      if (w_clear_busy) begin
        r_wr_en   <= 1'b1;
        r_wr_mask <= '1;
        r_wr_addr <= r_clear_cnt;
        r_wr_data <= '0;
      end else begin
        r_wr_en   <= |w_wr_grant;
        r_wr_mask <= w_wr_mask;
        r_wr_addr <= w_wr_addr;
        r_wr_data <= w_wr_data;
      end
      r_rd_en   <= |w_rd_grant;
      r_rd_addr <= w_rd_addr;
      r_rd_id   <= w_rd_grant;
      r_resp_en <= r_rd_en;
      r_resp_id <= r_rd_id;
    end
  end

  dual_port_blockram #(
    .SINGLE_ENTRY_WIDTH_IN_BITS(W), .NUM_SET(NUM_SET), .SET_PTR_WIDTH_IN_BITS(A),
    .WRITE_MASK_LEN(M), .CONFIG_MODE(CONFIG_MODE)
  ) u_ram (
    .i_clk(clk_in), .i_rst(reset_in),
    .i_write_en(r_wr_en), .i_write_mask(r_wr_mask), .i_write_addr(r_wr_addr), .i_write_data(r_wr_data),
    .i_read_en(r_rd_en), .i_read_addr(r_rd_addr),
    .o_read_data(w_ram_data), .o_read_valid(w_ram_valid)
  );

  assign bus.write_request_ready_out = w_wr_grant;
  assign bus.read_request_ready_out  = w_rd_grant;
  assign bus.read_response_valid_out = r_resp_id & {N{r_resp_en}};
  assign bus.read_response_hit_out   = w_ram_valid;
  assign bus.read_response_data_out  = w_ram_data;
  assign bus.clear_busy_out          = w_clear_busy;
  assign bus.clear_done_out          = r_clear_done;

`ifdef BLOCKRAM_ARBITER_PERF_COUNTER_EN
  logic [ARB_PERF_COUNTER_WIDTH-1:0] r_conflict_count;
  logic                              w_conflict;

  assign w_conflict = (|(bus.read_request_valid_in & ~w_rd_grant)) |
                      (|(bus.write_request_valid_in & ~w_wr_grant));

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)
      r_conflict_count <= '0;
    else if (w_conflict && (r_conflict_count != '1))
      r_conflict_count <= r_conflict_count + ARB_PERF_COUNTER_WIDTH'(1);
  end

  assign conflict_count_out = r_conflict_count;
`endif
endmodule
